lsu_mem_access: RTL
===================

Name: lsu_mem_access

Overview:
- MEM-stage load/store unit. It is the responder for the memory-control fields the decode stage emits (mem_we, mem_re, mem_size in funct3 encoding) and turns them into a data-bus transaction.
- Handles byte-lane steering, write strobes, load sign/zero extension and misalignment, and stalls the pipeline until the bus transaction completes.
- Sits between the EX/MEM pipeline register and the data-memory bus. Its result feeds the MEM/WB register.

Parameters:
- ADDR_W, 32, bus/address width in bits.
- DATA_W, 32, data width in bits; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  MEM-stage instruction valid
- mem_we_i  in  1  store request
- mem_re_i  in  1  load request
- mem_size_i  in  3  000=B, 001=H, 010=W, 100=BU, 101=HU
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- rd_addr_i  in  5  load destination register
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wstrb_o  out  4  byte write strobes
- bus_wdata_o  out  32  lane-replicated store data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data
- stall_o  out  1  freeze IF/ID/EX and MEM input
- done_o  out  1  one-cycle completion pulse
- rd_data_o  out  32  extended load result
- rd_addr_o  out  5  load destination
- reg_wen_o  out  1  write back rd_data_o
- misalign_o  out  1  misaligned access flagged (feature)

Behaviour:
- Reset values: state=IDLE; bus_req_o, bus_we_o, done_o, reg_wen_o, misalign_o = 0; bus_addr_o, bus_wstrb_o, bus_wdata_o, rd_data_o, rd_addr_o = 0.
- States and transitions:
  - IDLE: accept when req_valid_i & (mem_we_i | mem_re_i). Latch addr, size, wdata, rd, and we (mem_we_i wins if both are set). Go to REQ, or to DONE directly on an illegal size or a trapped misalignment.
  - REQ: bus_req_o=1. Address, strobe, wdata and we are held stable until bus_gnt_i is sampled high. On grant: store goes to DONE, load goes to WAIT.
  - WAIT: bus_req_o=0. On bus_rvalid_i, capture the extended data and go to DONE.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- stall_o = (state != IDLE && state != DONE) | (state == IDLE & req_valid_i & (mem_we_i | mem_re_i)). It is combinational, high in the accept cycle and low in the DONE cycle.
- Latency, with gnt and rvalid at the earliest possible cycle:
  - Store: accept at cycle 0, REQ at 1, DONE at 2.
  - Load: accept at 0, REQ at 1, WAIT at 2 (rvalid), DONE at 3.
  - Stall cycles grow one-for-one with gnt/rvalid delay. There is no timeout.
- Write strobes:
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << {addr[1],1'b0}
  - SW: 4'b1111
  - Loads: 4'b0000
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extract: lane = bus_rdata_i >> (8*addr[1:0]) (half-word uses addr[1] only).
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- Write-back outputs:
  - Load: rd_data_o, rd_addr_o and reg_wen_o are valid in DONE. reg_wen_o=1 only when the load completed over the bus and rd != 0.
  - Store: reg_wen_o=0.
  - reg_wen_o and done_o are 0 outside DONE. rd_data_o holds its last value.
- Illegal sizes:
  - Load sizes 011/110/111 and store sizes other than 000/001/010 are illegal.
  - No bus access; DONE the next cycle with reg_wen_o=0.
- Boundary conditions:
  - rvalid arriving while in IDLE or REQ is ignored.
  - A gnt without a request is ignored.
  - req_valid_i while busy is ignored; the pipeline must hold it because stall_o=1.
  - Reset mid-transaction: next edge goes to IDLE and drops bus_req_o. A late rvalid is ignored.
- Address width: bus_addr_o = {addr[31:2],2'b00}. Bytes in different words are never merged.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no bus request; DONE follows the accept cycle.
  - In DONE: misalign_o=1, reg_wen_o=0, rd_data_o = faulting address.
- Undefined:
  - Address low bits are forced to natural alignment (H clears bit 0, W clears bits 1:0) before strobe/lane computation.
  - misalign_o is tied to 0.

Test Plan:
- SW addr=0x1000 wdata=0xDEADBEEF, gnt on first REQ cycle -> bus_addr=0x1000, wstrb=1111, wdata=0xDEADBEEF; done_o at cycle 2; stall high at cycles 0-1; reg_wen_o=0.
- SB addr=0x1003 wdata=0x000000A5 -> wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000.
- LB addr=0x2001, rdata=0x12348056 -> rd_data_o=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr=0x2002 -> 0x00001234; LHU with rdata=0x8001xxxx -> 0x00008001.
- LW, gnt delayed 3 cycles and rvalid 2 cycles later -> bus_req/addr stable while waiting; done_o at cycle 7; reg_wen_o=1 with the given rd; stall drops exactly at DONE.
- Reset asserted in WAIT, then rvalid one cycle after reset -> state IDLE, done_o stays 0, bus_req_o=0; the next request proceeds normally.
- LW addr=0x3002:
  - With LSU_MISALIGN_TRAP_EN: no bus_req, done at cycle 1, misalign_o=1, rd_data_o=0x3002, reg_wen_o=0.
  - Without it: bus_addr=0x3000, normal load.

Source files
------------

// File: rtl/lsu_mem_access.sv
// -----------------------------------------------------------------------------
// lsu_mem_access : MEM-stage load/store unit for an RV32I pipeline.
//
// Turns the decode-stage memory controls (mem_we, mem_re, mem_size in funct3
// encoding) into a single data-bus transaction. It steers byte lanes, builds
// write strobes and sign/zero-extends load data, and stalls the pipeline until
// the transaction completes.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses skip the bus. They complete with
//               misalign_o=1 and rd_data_o set to the faulting address.
//   undefined : address low bits are forced to natural alignment and
//               misalign_o stays 0.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_i                   MEM-stage instruction valid
//   mem_we_i, mem_re_i            store / load request (store wins if both)
//   mem_size_i                    000=B 001=H 010=W 100=BU 101=HU
//   addr_i, wdata_i, rd_addr_i    effective address, store data, load rd
//   bus_req_o, bus_we_o           bus request / write
//   bus_addr_o                    word-aligned bus address
//   bus_wstrb_o, bus_wdata_o      byte strobes, lane-replicated store data
//   bus_gnt_i                     request accepted this cycle
//   bus_rvalid_i, bus_rdata_i     read data valid / read data
//   stall_o                       freeze IF/ID/EX and the MEM input
//   done_o                        one-cycle completion pulse
//   rd_data_o, rd_addr_o          extended load result and its destination
//   reg_wen_o                     write back rd_data_o
//   misalign_o                    misaligned access flagged (trap build only)
// -----------------------------------------------------------------------------
module lsu_mem_access #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   input  logic              mem_we_i,
   input  logic              mem_re_i,
   input  logic [2:0]        mem_size_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        rd_addr_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_wstrb_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [4:0]        rd_addr_o,
   output logic              reg_wen_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_r;
   logic [1:0]  lo_r;       // effective low address bits, for load lane select
   logic [2:0]  size_r;     // latched funct3 size, for load extension

   logic        accept_s;
   logic        legal_s;
   logic        misal_s;
   logic [1:0]  eff_lo_s;

   // Loads accept B/H/W/BU/HU; stores only B/H/W.
   function automatic logic size_legal(input logic we, input logic [2:0] size);
      logic ok;
      case (size)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = ~we;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
      logic mis;
      case (size[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction
`else
   // Force natural alignment: H drops bit 0, W drops bits 1:0.
   function automatic logic [1:0] align_lo(input logic [2:0] size, input logic [1:0] lo);
      logic [1:0] al;
      case (size[1:0])
         2'b01:   al = {lo[1], 1'b0};
         2'b10:   al = 2'b00;
         default: al = lo;
      endcase
      return al;
   endfunction
`endif

   function automatic logic [3:0] store_strobe(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] strb;
      case (size[1:0])
         2'b00:   strb = 4'b0001 << lo;
         2'b01:   strb = 4'b0011 << {lo[1], 1'b0};
         2'b10:   strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Replicate the store operand across every lane it could land in.
   function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] w);
      logic [31:0] d;
      case (size[1:0])
         2'b00:   d = {4{w[7:0]}};
         2'b01:   d = {2{w[15:0]}};
         default: d = w;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] lo,
                                               input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = rdata[{lo, 3'b000} +: 8];
      h = rdata[{lo[1], 4'b0000} +: 16];
      case (size)
         3'b000:  res = {{24{b[7]}}, b};
         3'b100:  res = {24'h000000, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b101:  res = {16'h0000, h};
         3'b010:  res = rdata;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   assign accept_s = (state_r == S_IDLE) & req_valid_i & (mem_we_i | mem_re_i);
   assign legal_s  = size_legal(mem_we_i, mem_size_i);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misal_s  = legal_s & is_misaligned(mem_size_i, addr_i[1:0]);
   assign eff_lo_s = addr_i[1:0];
`else
   assign misal_s  = 1'b0;
   assign eff_lo_s = align_lo(mem_size_i, addr_i[1:0]);
`endif

   // Stall covers the accept cycle and the bus phases, but never DONE.
   assign stall_o = (state_r == S_REQ) | (state_r == S_WAIT) | accept_s;

   // Transaction FSM with all bus and write-back outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         lo_r        <= 2'b00;
         size_r      <= 3'b000;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= {ADDR_W{1'b0}};
         bus_wstrb_o <= 4'b0000;
         bus_wdata_o <= {DATA_W{1'b0}};
         done_o      <= 1'b0;
         rd_data_o   <= {DATA_W{1'b0}};
         rd_addr_o   <= 5'd0;
         reg_wen_o   <= 1'b0;
         misalign_o  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  lo_r      <= eff_lo_s;
                  size_r    <= mem_size_i;
                  rd_addr_o <= rd_addr_i;
                  if (!legal_s) begin
                     // Illegal size: complete without touching the bus.
                     state_r <= S_DONE;
                     done_o  <= 1'b1;
                  end else if (misal_s) begin
                     state_r    <= S_DONE;
                     done_o     <= 1'b1;
                     misalign_o <= 1'b1;
                     rd_data_o  <= addr_i;
                  end else begin
                     state_r     <= S_REQ;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= mem_we_i;
                     bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                     bus_wstrb_o <= mem_we_i ? store_strobe(mem_size_i, eff_lo_s) : 4'b0000;
                     bus_wdata_o <= store_data(mem_size_i, wdata_i);
                  end
               end
            end
            S_REQ: begin
               // Address, strobes, data and we stay put until the grant.
               if (bus_gnt_i) begin
                  bus_req_o <= 1'b0;
                  if (bus_we_o) begin
                     state_r <= S_DONE;
                     done_o  <= 1'b1;
                  end else begin
                     state_r <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus_rvalid_i) begin
                  rd_data_o <= load_extend(size_r, lo_r, bus_rdata_i);
                  reg_wen_o <= (rd_addr_o != 5'd0);
                  done_o    <= 1'b1;
                  state_r   <= S_DONE;
               end
            end
            S_DONE: begin
               state_r    <= S_IDLE;
               done_o     <= 1'b0;
               reg_wen_o  <= 1'b0;
               misalign_o <= 1'b0;
            end
            default: begin
               state_r    <= S_IDLE;
               bus_req_o  <= 1'b0;
               done_o     <= 1'b0;
               reg_wen_o  <= 1'b0;
               misalign_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
